// File: rtl/sirq_pkg.sv
// rtl/sirq_pkg.sv - shared constants, types and priority encoder for the sound IRQ controller
package sirq_pkg;

    localparam int SIRQ_MAX_SRC = 8;

    localparam logic SIRQ_EDGE  = 1'b0;
    localparam logic SIRQ_LEVEL = 1'b1;

    typedef logic [7:0] sirq_vec_t;

    // Index of the lowest set bit (highest priority); 0 when nothing is set.
    function automatic logic [2:0] sirq_first_set(input logic [SIRQ_MAX_SRC-1:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = SIRQ_MAX_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sirq_src_det.sv
// rtl/sirq_src_det.sv - per-source request history and edge/level trigger detection
module sirq_src_det
    import sirq_pkg::*;
#(
    parameter logic MODE = SIRQ_EDGE
)(
    input  logic clk_49m,
    input  logic sirq_clr,
    input  logic cen,
    input  logic req,
    input  logic en,
    output logic trig
);

    logic hist;

    // History resets to one so a request held high across an acknowledge is not seen as a new edge.
    always_ff @(posedge clk_49m or posedge sirq_clr) begin
        if (sirq_clr) begin
            hist <= 1'b1;
        end else if (cen) begin
            hist <= req;
        end
    end

    assign trig = en & req & ((MODE == SIRQ_LEVEL) | ~hist);

endmodule

// File: rtl/sound_irq_ctrl.sv
// rtl/sound_irq_ctrl.sv - N-source interrupt controller with hold-off and IM2 vector for the sound Z80
module sound_irq_ctrl
    import sirq_pkg::*;
#(
    parameter int                      N_SRC      = 2,
    parameter logic [SIRQ_MAX_SRC-1:0] LEVEL_MASK = '0,
    parameter int                      HOLDOFF    = 2,
    parameter int                      VEC_STEP   = 2
)(
    input  logic             clk_49m,
    input  logic             sirq_clr,
    input  logic             cen,
    input  logic [N_SRC-1:0] src_req,
    input  logic [N_SRC-1:0] src_en,
    input  sirq_vec_t        vec_base,
    output logic             int_n,
    output sirq_vec_t        int_vec,
    output logic [N_SRC-1:0] pending,
    output logic [7:0]       coalesce_cnt
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);
    localparam sirq_vec_t  STEP      = sirq_vec_t'(VEC_STEP);

    logic [N_SRC-1:0]        trig;
    logic [N_SRC-1:0]        pending_next;
    logic [N_SRC-1:0]        active;
    logic [SIRQ_MAX_SRC-1:0] active_wide;
    logic [3:0]              hold_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            sirq_src_det #(
                .MODE (LEVEL_MASK[gi])
            ) u_det (
                .clk_49m  (clk_49m),
                .sirq_clr (sirq_clr),
                .cen      (cen),
                .req      (src_req[gi]),
                .en       (src_en[gi]),
                .trig     (trig[gi])
            );
        end
    endgenerate

    assign pending_next = pending | trig;
    assign active       = pending & src_en;

    // Pending, coalesce, hold-off and int_n registers; the hold-off mask uses the pre-decrement count.
    always_ff @(posedge clk_49m or posedge sirq_clr) begin
        if (sirq_clr) begin
            pending      <= '0;
            int_n        <= 1'b1;
            coalesce_cnt <= 8'd0;
            hold_cnt     <= HOLD_INIT;
        end else if (cen) begin
            pending <= pending_next;
            if ((|(trig & pending)) && (coalesce_cnt != 8'hFF)) begin
                coalesce_cnt <= coalesce_cnt + 8'd1;
            end
            if (hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
            int_n <= ~(|(pending_next & src_en)) | (hold_cnt != 4'd0);
        end
    end

    // Vector of the highest-priority enabled pending source; follows src_en without waiting for cen.
    always_comb begin
        active_wide = '0;
        active_wide[N_SRC-1:0] = active;
        int_vec = vec_base;
        if (|active_wide) begin
            int_vec = vec_base + sirq_vec_t'(sirq_first_set(active_wide)) * STEP;
        end
    end

endmodule

// File: tb/tb_sound_irq_ctrl.sv
// tb/tb_sound_irq_ctrl.sv - scoreboard bench for sound_irq_ctrl
module tb_sound_irq_ctrl;

    logic       clk_49m = 1'b0;
    logic       cen;
    logic       clr_a, clr_b;
    logic [1:0] req_a, en_a, req_b, en_b;
    logic [7:0] base_a, base_b;
    logic       int_n_a, int_n_b;
    logic [7:0] vec_a, vec_b, coal_a, coal_b;
    logic [1:0] pend_a, pend_b;

    always #5 clk_49m = ~clk_49m;

    sound_irq_ctrl #(.N_SRC(2), .LEVEL_MASK(8'h00), .HOLDOFF(0), .VEC_STEP(2)) dut_a (
        .clk_49m      (clk_49m),
        .sirq_clr     (clr_a),
        .cen          (cen),
        .src_req      (req_a),
        .src_en       (en_a),
        .vec_base     (base_a),
        .int_n        (int_n_a),
        .int_vec      (vec_a),
        .pending      (pend_a),
        .coalesce_cnt (coal_a)
    );

    sound_irq_ctrl #(.N_SRC(2), .LEVEL_MASK(8'h01), .HOLDOFF(2), .VEC_STEP(2)) dut_b (
        .clk_49m      (clk_49m),
        .sirq_clr     (clr_b),
        .cen          (cen),
        .src_req      (req_b),
        .src_en       (en_b),
        .vec_base     (base_b),
        .int_n        (int_n_b),
        .int_vec      (vec_b),
        .pending      (pend_b),
        .coalesce_cnt (coal_b)
    );

    localparam int K_INTN_A = 0;
    localparam int K_PEND_A = 1;
    localparam int K_VEC_A  = 2;
    localparam int K_COAL_A = 3;
    localparam int K_INTN_B = 4;
    localparam int K_PEND_B = 5;
    localparam int K_VEC_B  = 6;

    typedef struct {
        int          kind;
        string       tag;
        int unsigned exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_INTN_A: return {31'd0, int_n_a};
            K_PEND_A: return {30'd0, pend_a};
            K_VEC_A:  return {24'd0, vec_a};
            K_COAL_A: return {24'd0, coal_a};
            K_INTN_B: return {31'd0, int_n_b};
            K_PEND_B: return {30'd0, pend_b};
            K_VEC_B:  return {24'd0, vec_b};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_exp(input int kind, input string tag, input int unsigned exp);
        exp_t e;
        e.kind = kind;
        e.tag  = tag;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic tick();
        cen = 1'b1;
        @(negedge clk_49m);
        cen = 1'b0;
    endtask

    task automatic expect_a(input string tag, input int unsigned intn, input int unsigned pend,
                            input int unsigned vec, input int unsigned coal);
        push_exp(K_INTN_A, {tag, ".int_n"}, intn);
        push_exp(K_PEND_A, {tag, ".pending"}, pend);
        push_exp(K_VEC_A,  {tag, ".int_vec"}, vec);
        push_exp(K_COAL_A, {tag, ".coalesce"}, coal);
    endtask

    initial begin
        cen    = 1'b0;
        clr_a  = 1'b1;
        clr_b  = 1'b1;
        req_a  = 2'b00;
        en_a   = 2'b11;
        base_a = 8'hF0;
        req_b  = 2'b01;
        en_b   = 2'b01;
        base_b = 8'h10;
        repeat (3) @(negedge clk_49m);

        expect_a("reset_a", 1, 0, 8'hF0, 0);
        push_exp(K_INTN_B, "reset_b.int_n", 1);
        push_exp(K_PEND_B, "reset_b.pending", 0);
        drain();

        // Edge config: single pulse on source 1
        @(negedge clk_49m);
        clr_a = 1'b0;
        tick();
        expect_a("idle", 1, 0, 8'hF0, 0);
        drain();
        req_a = 2'b10;
        tick();
        expect_a("src1_pulse", 0, 2'b10, 8'hF2, 0);
        drain();
        req_a = 2'b00;
        tick();
        expect_a("src1_sticky", 0, 2'b10, 8'hF2, 0);
        drain();

        // Both sources on one tick; source 1 was already pending so it coalesces
        req_a = 2'b11;
        tick();
        expect_a("both", 0, 2'b11, 8'hF0, 1);
        drain();

        // Acknowledge with source 0 held high
        req_a = 2'b01;
        clr_a = 1'b1;
        expect_a("ack_async", 1, 0, 8'hF0, 0);
        drain();
        repeat (3) @(negedge clk_49m);
        clr_a = 1'b0;
        tick();
        expect_a("held_no_retrig1", 1, 0, 8'hF0, 0);
        drain();
        tick();
        expect_a("held_no_retrig2", 1, 0, 8'hF0, 0);
        drain();
        req_a = 2'b00;
        tick();
        req_a = 2'b01;
        tick();
        expect_a("re_rise", 0, 2'b01, 8'hF0, 0);
        drain();

        // Coalesce saturation
        for (int p = 1; p <= 300; p++) begin
            req_a = 2'b00;
            tick();
            req_a = 2'b01;
            tick();
            if (p == 10) begin
                push_exp(K_COAL_A, "coal_10", 10);
                drain();
            end
        end
        push_exp(K_COAL_A, "coal_sat", 255);
        push_exp(K_INTN_A, "coal_sat.int_n", 0);
        drain();
        clr_a = 1'b1;
        push_exp(K_COAL_A, "coal_clr", 0);
        drain();
        @(negedge clk_49m);
        clr_a = 1'b0;

        // Enable masking of a pending source
        req_a = 2'b00;
        tick();
        req_a = 2'b10;
        tick();
        req_a = 2'b00;
        expect_a("mask_pend", 0, 2'b10, 8'hF2, 0);
        drain();
        en_a = 2'b01;
        push_exp(K_VEC_A,  "mask_vec_now", 8'hF0);
        push_exp(K_INTN_A, "mask_intn_wait", 0);
        drain();
        tick();
        expect_a("masked", 1, 2'b10, 8'hF0, 0);
        drain();
        en_a = 2'b11;
        push_exp(K_VEC_A,  "unmask_vec_now", 8'hF2);
        push_exp(K_INTN_A, "unmask_intn_wait", 1);
        drain();
        tick();
        push_exp(K_INTN_A, "unmasked.int_n", 0);
        drain();
        base_a = 8'hFF;
        push_exp(K_VEC_A, "vec_wrap", 8'h01);
        drain();

        // Level source with hold-off after release
        clr_b = 1'b0;
        repeat (3) @(negedge clk_49m);
        push_exp(K_INTN_B, "no_cen_hold.int_n", 1);
        push_exp(K_PEND_B, "no_cen_hold.pending", 0);
        drain();
        tick();
        push_exp(K_INTN_B, "hold_t1.int_n", 1);
        push_exp(K_PEND_B, "hold_t1.pending", 1);
        drain();
        tick();
        push_exp(K_INTN_B, "hold_t2.int_n", 1);
        drain();
        tick();
        push_exp(K_INTN_B, "hold_t3.int_n", 0);
        push_exp(K_VEC_B,  "hold_t3.int_vec", 8'h10);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_irq_ctrl.md
# sound_irq_ctrl

Parametrised interrupt controller for the sound Z80. It generalises the single sound-latch IRQ into N request sources. Each source can be edge- or level-triggered and individually enabled, and the block adds a post-acknowledge hold-off and an IM2 vector output. It sits between the main-CPU sound-latch write strobe (plus any timer or chip IRQ sources) and the T80 `INT_n`. The block is cleared by the Z80 interrupt-acknowledge/reset strobe.

## Interface
Parameters:
- `N_SRC`, 2: number of request sources (1..8); index 0 has highest priority.
- `LEVEL_MASK`, 0: bit i = 1 makes source i level-triggered; 0 makes it rising-edge-triggered.
- `HOLDOFF`, 2: number of `cen` ticks during which `int_n` is forced high after reset release (0..15).
- `VEC_STEP`, 2: vector spacing between sources.

Ports:
- `clk_49m`  in  1  system clock, 49.152 MHz.
- `sirq_clr`  in  1  reset: asynchronous, active-high. It is driven by system reset OR Z80 acknowledge (`~M1_n & ~IORQ_n`).
- `cen`  in  1  sound clock enable (3.072 MHz, fixed or fractional); all state advances only on `cen`.
- `src_req`  in  N_SRC  request inputs, sampled on `cen`.
- `src_en`  in  N_SRC  per-source enable.
- `vec_base`  in  8  IM2 vector base.
- `int_n`  out  1  active-low interrupt to the Z80, registered.
- `int_vec`  out  8  vector of the highest-priority enabled pending source.
- `pending`  out  N_SRC  pending flags, registered.
- `coalesce_cnt`  out  8  saturating count of requests merged into an already-pending source.

## Operation
- Reset values while `sirq_clr` is high: `pending`=0; `int_n`=1; `coalesce_cnt`=0; hold-off counter=`HOLDOFF`; edge-history register=all ones.
  - Because history resets to ones, an edge source still high across an acknowledge does not retrigger.
- On each `cen` (while `sirq_clr` is low), a trigger for source i is:
  - for edge sources: `src_req[i] & ~hist[i]`;
  - for level sources: `src_req[i]`.
  - In both cases the trigger is ANDed with `src_en[i]`.
- `hist` is updated with `src_req` on every `cen`, regardless of enable.
- `pending_next` = `pending | trig`. Pending bits clear only via `sirq_clr`; there is no per-source clear, so an acknowledge clears all sources.
- Coalesce: on a `cen`, if any i has both `trig[i]` and `pending[i]`, `coalesce_cnt` increments by 1. It saturates at 255. Multiple coalesces on the same tick count once.
- Hold-off: the counter decrements on each `cen` while it is nonzero.
- `int_n` <= ~(|(`pending_next` & `src_en`)) OR (counter != 0), evaluated using the counter value before the decrement.
- `int_vec`: combinational from registered `pending & src_en`.
  - k is the lowest set index; `int_vec` = (`vec_base` + k*`VEC_STEP`) mod 256.
  - If nothing is set, `int_vec` = `vec_base`.
- Disabling a source does not clear its pending bit. It only masks `int_n` and `int_vec`, and re-enabling reasserts them.

## Timing
- Request to `int_n` low: `src_req` is high at `cen` tick k; `pending` and `int_n` update on that same clock edge, so `int_n` is low one `clk_49m` after tick k.
- This holds only when the hold-off counter is already 0. Otherwise `int_n` falls on the first `cen` after the counter reaches 0.
- `sirq_clr` asserted: `int_n` goes high asynchronously within the same cycle, and all state is held cleared for as long as `sirq_clr` stays high.
- An edge source that rises while `sirq_clr` is high is lost, because history resets to ones. A level source re-pends on the first `cen` after release but stays masked for `HOLDOFF` ticks.
- Simultaneous triggers on several sources: all pending bits set together; `int_vec` selects the lowest index.
- A `src_en` change takes effect on `int_n` at the next `cen`, and on `int_vec` immediately.
- `cen` low: all registers hold, including the hold-off counter.

## Structure
- Package `sirq_pkg` holds:
  - `SIRQ_MAX_SRC` = 8;
  - `SIRQ_EDGE` = 1'b0 and `SIRQ_LEVEL` = 1'b1 mode constants;
  - the `sirq_vec_t` typedef (8-bit);
  - the priority-encoder function `sirq_first_set`.
- Sub-module `sirq_src_det`, one instance per source, holds the history flop plus the trigger logic, with the mode as a parameter.
- Top level holds the pending register, coalesce counter, hold-off counter, `int_n` register and vector mux.

## Test plan
- Config `N_SRC`=2, `HOLDOFF`=0, `vec_base`=8'hF0, `src_en`=2'b11. Pulse `src_req[1]` for one `cen` -> `pending`=2'b10, `int_n`=0 one clock after that tick, `int_vec`=8'hF2.
- Both sources trigger on the same `cen` -> `pending`=2'b11 and `int_vec`=8'hF0. Then pulse `sirq_clr` for 3 clocks -> `int_n`=1 and `pending`=0 immediately.
- Edge source 0 held high through the acknowledge -> no retrigger after release. Drop it and raise it again -> `int_n` goes low again.
- `HOLDOFF`=2 with level source 0 held high:
  - after `sirq_clr` release, `int_n` stays 1 for 2 `cen` ticks;
  - `pending[0]`=1 from tick 1;
  - `int_n` goes low at tick 3.
- Source 0 pending; pulse it 300 more times -> `coalesce_cnt` saturates at 255. Then `sirq_clr` -> `coalesce_cnt`=0.
- Pending source 1 with `src_en`=2'b01 -> `int_n`=1 and `int_vec`=`vec_base`. Set `src_en`=2'b11 -> `int_n`=0 on the next `cen`, and `int_vec`=`vec_base`+2.
